// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise ALU pipeline: op-code width and encodings.
package bitwise_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NAND  = 3'b011,
    OP_NOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_ANDN  = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

endpackage : bitwise_pkg

// File: rtl/bitwise_alu_pipe_if.sv
// Operand/result handshake bundle between the upstream source, the ALU
// pipeline and the downstream consumer.
interface bitwise_alu_pipe_if
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) ();

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Upstream side
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [OP_W-1:0]   op;
  logic              acc_en;

  // Downstream side
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  q;
  logic              zero;
  logic              parity;
  logic [CNT_W-1:0]  popcount;

  // Environment view: drives operands and consumer readiness
  modport master (
    output in_valid, a, b, op, acc_en, out_ready,
    input  in_ready, out_valid, q, zero, parity, popcount
  );

  // ALU pipeline view
  modport slave (
    input  in_valid, a, b, op, acc_en, out_ready,
    output in_ready, out_valid, q, zero, parity, popcount
  );

endinterface : bitwise_alu_pipe_if

// File: rtl/bitwise_core.sv
// Combinational bitwise operation unit with result status flags.
module bitwise_core
  import bitwise_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_parity,
  output logic [CNT_W-1:0] o_popcount
);

  logic [WIDTH-1:0] w_result;
  logic [CNT_W-1:0] w_count;

  // Select the bitwise operation
  always_comb begin
    w_result = '0;
    unique case (op_e'(i_op))
      OP_AND:   w_result = i_a & i_b;
      OP_OR:    w_result = i_a | i_b;
      OP_XOR:   w_result = i_a ^ i_b;
      OP_NAND:  w_result = ~(i_a & i_b);
      OP_NOR:   w_result = ~(i_a | i_b);
      OP_XNOR:  w_result = ~(i_a ^ i_b);
      OP_ANDN:  w_result = i_a & ~i_b;
      OP_PASSB: w_result = i_b;
      default:  w_result = '0;
    endcase
  end

  // Count set bits of the result
  always_comb begin
    w_count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_count = w_count + CNT_W'(w_result[i]);
    end
  end

  assign o_result   = w_result;
  assign o_zero     = (w_result == '0);
  assign o_parity   = ^w_result;
  assign o_popcount = w_count;

endmodule : bitwise_core

// File: rtl/bitwise_alu_pipe.sv
// Two-stage pipelined bitwise ALU with valid/ready handshakes, an accumulator
// that chains results, and registered status flags.
module bitwise_alu_pipe
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  bitwise_alu_pipe_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Stage 1: captured operation
  logic              r_s1_valid;
  logic [WIDTH-1:0]  r_s1_a;
  logic [WIDTH-1:0]  r_s1_b;
  logic [OP_W-1:0]   r_s1_op;
  logic              r_s1_acc_en;

  // Stage 2: registered result and flags
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_q;
  logic              r_zero;
  logic              r_parity;
  logic [CNT_W-1:0]  r_popcount;

  // Accumulator: last result that moved into stage 2
  logic [WIDTH-1:0]  r_acc;

  logic              w_s2_advance;
  logic              w_s1_to_s2;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_consume;
  logic [WIDTH-1:0]  w_eff_a;
  logic [WIDTH-1:0]  w_result;
  logic              w_zero;
  logic              w_parity;
  logic [CNT_W-1:0]  w_popcount;

  assign w_s2_advance = !r_out_valid || bus.out_ready;
  assign w_s1_to_s2   = r_s1_valid && w_s2_advance;
  assign w_in_ready   = !rst && (!r_s1_valid || w_s2_advance);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_consume    = r_out_valid && bus.out_ready;

  // The accumulator is refreshed on every stage transfer, so an acc_en op
  // directly behind another always sees its predecessor's result.
  assign w_eff_a = r_s1_acc_en ? r_acc : r_s1_a;

  bitwise_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a        (w_eff_a),
    .i_b        (r_s1_b),
    .i_op       (r_s1_op),
    .o_result   (w_result),
    .o_zero     (w_zero),
    .o_parity   (w_parity),
    .o_popcount (w_popcount)
  );

  // Stage-1 valid: set on accept, cleared when its op moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
    end else if (w_s1_to_s2) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage-1 data: captured on accept only, no reset needed
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_a      <= bus.a;
      r_s1_b      <= bus.b;
      r_s1_op     <= bus.op;
      r_s1_acc_en <= bus.acc_en;
    end
  end

  // Stage 2: load result and flags on transfer, drop valid when consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_zero      <= 1'b1;
      r_parity    <= 1'b0;
      r_popcount  <= '0;
    end else if (w_s1_to_s2) begin
      r_out_valid <= 1'b1;
      r_q         <= w_result;
      r_zero      <= w_zero;
      r_parity    <= w_parity;
      r_popcount  <= w_popcount;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  // Accumulator follows every stage transfer regardless of acc_en
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_s1_to_s2) begin
      r_acc <= w_result;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.q         = r_q;
  assign bus.zero      = r_zero;
  assign bus.parity    = r_parity;
  assign bus.popcount  = r_popcount;

endmodule : bitwise_alu_pipe

// File: doc/bitwise_alu_pipe.md
Name: bitwise_alu_pipe

Overview:
Parametrised, pipelined successor to the team's registered bitwise-operation unit.
- Extends the operation set from 4 to 8 ops and generalises operand width.
- Adds a valid/ready handshake on both sides, an accumulator mode that chains results, and result status flags.
- Sits between an upstream operand source and a downstream consumer. Two register stages; full throughput when the consumer is ready.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..64)
CNT_W, $clog2(WIDTH+1), width of popcount output (derived localparam, not overridable)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream has an operation
in_ready  out  1  block can accept an operation this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  3  operation select
acc_en  in  1  1: use accumulator in place of operand A
out_valid  out  1  q and flags hold a result
out_ready  in  1  downstream accepts the result
q  out  WIDTH  result
zero  out  1  q == 0
parity  out  1  XOR-reduction of q
popcount  out  CNT_W  number of 1 bits in q

Behaviour:
- Op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NAND
  - 100 NOR, 101 XNOR, 110 ANDN (A & ~B), 111 PASSB (result = B)
- Stage 1 (input register): captures a, b, op, acc_en when in_valid && in_ready; s1_valid set.
- Compute occurs combinationally from stage-1 contents. Effective A = acc if s1 acc_en, else s1 a.
- Stage 2 (output register): on s1->s2 transfer, q, zero, parity, popcount are loaded and out_valid is set.
- Accumulator (WIDTH bits) is loaded with the computed result on every s1->s2 transfer, regardless of acc_en. Back-to-back acc_en ops are therefore hazard-free.
- Transfer rules:
  - s2_advance = !out_valid || out_ready.
  - s1->s2 occurs when s1_valid && s2_advance.
  - in_ready = !rst && (!s1_valid || s2_advance).
- Output consumed when out_valid && out_ready. out_valid clears unless a new result loads the same cycle.
- Latency: operation accepted in cycle N appears with out_valid=1 in cycle N+2 when unstalled.
- Throughput: 1 op/cycle with out_ready held high.
- Backpressure: with out_ready=0, the pipeline holds at most 2 ops.
  - q and flags stay stable while out_valid && !out_ready.
  - No op is lost or duplicated.
- Simultaneous accept, transfer and consume in one cycle is legal and keeps full throughput.
- Reset, including mid-operation:
  - s1_valid=0, out_valid=0, q=0, zero=1, parity=0, popcount=0, acc=0.
  - In-flight ops are discarded. in_ready=0 while rst is high.
- Stage-1 data registers need no reset; only valid bits, outputs and acc are reset.
- Flags always describe the registered q (zero=1 after reset is consistent with q=0).
- No arithmetic carries; all ops are bitwise at width WIDTH. popcount is zero-extended to CNT_W.

Decomposition:
- Package bitwise_pkg: op-code localparams (OP_AND..OP_PASSB), OP_W=3.
- Sub-module bitwise_core (combinational):
  - Inputs: a, b, op.
  - Outputs: result, zero, parity, popcount.
  - Parametrised by WIDTH.
- Top keeps handshake, stage registers and accumulator.

Test Plan:
- WIDTH=8, out_ready=1, op=AND, a=0xF0, b=0x3C accepted cycle N -> cycle N+2: out_valid=1, q=0x30, zero=0, parity=0, popcount=2.
- Accumulate chain, back-to-back with out_ready=1:
  - PASSB b=0xAA -> q=0xAA.
  - XOR acc_en=1 b=0xFF -> q=0x55.
  - XOR acc_en=1 b=0x55 -> q=0x00, zero=1.
  - All three results on consecutive cycles.
- Backpressure: out_ready=0, offer 3 ops (AND 0xFF/0x0F, OR 0x01/0x02, XOR 0x0F/0xFF).
  - in_ready drops after 2 accepted.
  - Then raise out_ready -> results 0x0F, 0x03, 0xF0 in order, each exactly once.
- Op sweep: a=0xC5, b=0x5A for op 000..111 -> 0x40, 0xDF, 0x9F, 0xBF, 0x20, 0x60, 0x85, 0x5A; flags match each result.
- Reset mid-flight: two ops in pipe, assert rst 1 cycle.
  - Next cycle: out_valid=0, q=0, zero=1, in_ready=0 during rst.
  - Then XOR acc_en=1 b=0x3C -> q=0x3C (acc was cleared).
- WIDTH=13: NAND a=0x1FFF b=0x1FFF -> q=0x0000, zero=1; NOR a=0 b=0 -> q=0x1FFF, popcount=13, parity=1.
